// File: rtl/controller_mc_if.sv
// controller_mc_if: control/status bundle between controller_mc (master) and the multi-cycle datapath (slave).
interface controller_mc_if #(parameter int CNT_W = 32);
   logic [6:0]       op;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic             Zero;
   logic             lt;
   logic             PCWrite;
   logic             AdrSrc;
   logic             MemWrite;
   logic             IRWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [2:0]       ALUControl;
   logic [2:0]       ImmSrc;
   logic             RegWrite;
   logic             done;
   logic [CNT_W-1:0] instr_count;
   modport master (
      input  op, funct3, funct7, Zero, lt,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite, done, instr_count
   );
   modport slave (
      output op, funct3, funct7, Zero, lt,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite, done, instr_count
   );
endinterface

// File: rtl/controller_mc.sv
// controller_mc: multi-cycle RISC-V control FSM; outputs are registered against the next state,
// except branch PCWrite (needs this cycle's Zero/lt) and ImmSrc (pure decode of op).
module controller_mc #(
   parameter logic [6:0] HALT_OP = 7'b0000000,
   parameter int          CNT_W   = 32
) (
   input logic            clk,
   input logic            rst,
   controller_mc_if.master bus
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
      ALUWB, JAL, JALR, JALRWB, BRANCH, LUI, HALT
   } state_t;
   typedef struct packed {
      logic       pcw, adr, mw, irw, rw, done, br;
      logic [1:0] rs, sa, sb;
      logic [2:0] alu;
   } ctl_t;

   function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
      return f3 == 3'b000 ? {2'b00, sub} : f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 :
             f3 == 3'b100 ? 3'b100 : f3 == 3'b010 ? 3'b101 : 3'b000;
   endfunction

   function automatic ctl_t ctl_of(input state_t s, input logic [2:0] f3, input logic f7b);
      ctl_t c;
      c = '0;
      case (s)
         FETCH:    begin c.irw = 1'b1; c.pcw = 1'b1; c.sb = 2'b10; c.rs = 2'b10; end
         DECODE:   begin c.sa = 2'b01; c.sb = 2'b01; end
         MEMADR:   begin c.sa = 2'b10; c.sb = 2'b01; end
         MEMREAD:  c.adr = 1'b1;
         MEMWB:    begin c.rs = 2'b01; c.rw = 1'b1; end
         MEMWRITE: begin c.adr = 1'b1; c.mw = 1'b1; end
         EXECR:    begin c.sa = 2'b10; c.alu = alu_of(f3, f7b); end
         EXECI:    begin c.sa = 2'b10; c.sb = 2'b01; c.alu = alu_of(f3, 1'b0); end
         ALUWB:    c.rw = 1'b1;
         JAL:      begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; end
         JALR:     begin c.sa = 2'b10; c.sb = 2'b01; c.rs = 2'b10; c.pcw = 1'b1; end
         JALRWB:   begin c.sa = 2'b01; c.sb = 2'b10; c.rs = 2'b10; c.rw = 1'b1; end
         BRANCH:   begin c.sa = 2'b10; c.alu = 3'b001; c.br = 1'b1; end
         LUI:      begin c.rs = 2'b11; c.rw = 1'b1; end
         HALT:     c.done = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_t           r_state;
   state_t           w_next;
   ctl_t             r_ctl;
   logic [CNT_W-1:0] r_cnt;
   logic             w_taken;

   always_comb begin
      w_next = FETCH;
      case (r_state)
         FETCH:    w_next = DECODE;
         DECODE:   w_next = bus.op == HALT_OP ? HALT :
                            (bus.op == 7'h03 || bus.op == 7'h23) ? MEMADR :
                            bus.op == 7'h33 ? EXECR : bus.op == 7'h13 ? EXECI :
                            bus.op == 7'h6F ? JAL : bus.op == 7'h67 ? JALR :
                            bus.op == 7'h63 ? BRANCH : bus.op == 7'h37 ? LUI : HALT;
         MEMADR:   w_next = bus.op == 7'h03 ? MEMREAD : MEMWRITE;
         MEMREAD:  w_next = MEMWB;
         EXECR:    w_next = ALUWB;
         EXECI:    w_next = ALUWB;
         JAL:      w_next = ALUWB;
         JALR:     w_next = JALRWB;
         HALT:     w_next = HALT;
         default:  w_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= FETCH;
         r_ctl   <= ctl_of(FETCH, 3'b000, 1'b0);
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_ctl   <= ctl_of(w_next, bus.funct3, bus.funct7[5]);
         if (w_next == FETCH && r_state != FETCH) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign w_taken = bus.funct3 == 3'b000 ? bus.Zero : bus.funct3 == 3'b001 ? !bus.Zero :
                    bus.funct3 == 3'b100 ? bus.lt : bus.funct3 == 3'b101 ? !bus.lt : 1'b0;

   // enables are gated by rst so an in-flight write is dropped the moment reset asserts
   assign bus.PCWrite     = rst & (r_ctl.pcw | (r_ctl.br & w_taken));
   assign bus.IRWrite     = rst & r_ctl.irw;
   assign bus.MemWrite    = rst & r_ctl.mw;
   assign bus.RegWrite    = rst & r_ctl.rw;
   assign bus.AdrSrc      = r_ctl.adr;
   assign bus.ResultSrc   = r_ctl.rs;
   assign bus.ALUSrcA     = r_ctl.sa;
   assign bus.ALUSrcB     = r_ctl.sb;
   assign bus.ALUControl  = r_ctl.alu;
   assign bus.done        = r_ctl.done;
   assign bus.instr_count = r_cnt;
   assign bus.ImmSrc      = (bus.op == 7'h03 || bus.op == 7'h13 || bus.op == 7'h67) ? 3'b000 :
                            bus.op == 7'h23 ? 3'b001 : bus.op == 7'h63 ? 3'b010 :
                            bus.op == 7'h6F ? 3'b011 : bus.op == 7'h37 ? 3'b100 : 3'b000;
endmodule

// File: tb/tb_controller_mc.sv
// tb_controller_mc: directed instruction stream; per-cycle model indexed by cycle-within-instruction.
module tb_controller_mc;
   logic        clk = 1'b0;
   logic        rst;
   int          errors = 0;
   int          checks = 0;
   int          cur_k = 0;
   int          m_cnt = 0;
   logic        active = 1'b0;
   logic [17:0] act;

   localparam logic [17:0] M_PCW = 18'h20000, M_RS = 18'h03000, M_ALU = 18'h000E0,
                           M_RW = 18'h00002, M_DONE = 18'h00001, M_EN = 18'h2C003;

   controller_mc_if #(.CNT_W(32)) b();
   controller_mc dut (.clk(clk), .rst(rst), .bus(b));

   always #5 clk = ~clk;

   assign act = {b.PCWrite, b.AdrSrc, b.MemWrite, b.IRWrite, b.ResultSrc, b.ALUSrcA,
                 b.ALUSrcB, b.ALUControl, b.ImmSrc, b.RegWrite, b.done};

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   function automatic logic [17:0] pk(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb,
                                      input logic [2:0] alu, imm, input logic rw, dn);
      return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn};
   endfunction

   function automatic int cpi(input logic [6:0] o);
      return o == 7'h03 ? 5 : (o == 7'h23 || o == 7'h33 || o == 7'h13 || o == 7'h6F || o == 7'h67) ? 4 :
             (o == 7'h63 || o == 7'h37) ? 3 : 0;
   endfunction

   function automatic logic [2:0] m_alu(input logic [2:0] f3, input logic sub);
      logic [2:0] tbl [8];
      tbl = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd4, 3'd0, 3'd3, 3'd2};
      return (f3 == 3'd0 && sub) ? 3'd1 : tbl[f3];
   endfunction

   // expected control word for cycle k of the instruction (k=0 is its FETCH cycle)
   function automatic logic [17:0] model(input logic [6:0] o, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic z, l, input int k);
      logic [2:0] imm;
      logic       tk;
      imm = (o == 7'h23) ? 3'd1 : (o == 7'h63) ? 3'd2 : (o == 7'h6F) ? 3'd3 : (o == 7'h37) ? 3'd4 : 3'd0;
      tk  = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && l) || (f3 == 3'd5 && !l);
      if (k == 0) return pk(1, 0, 0, 1, 2, 0, 2, 0, imm, 0, 0);
      if (k == 1) return pk(0, 0, 0, 0, 0, 1, 1, 0, imm, 0, 0);
      if (cpi(o) == 0) return pk(0, 0, 0, 0, 0, 0, 0, 0, imm, 0, 1);
      if (k == cpi(o) - 1 && (o == 7'h33 || o == 7'h13 || o == 7'h6F))
         return pk(0, 0, 0, 0, 0, 0, 0, 0, imm, 1, 0);
      case (o)
         7'h03, 7'h23: return k == 2 ? pk(0, 0, 0, 0, 0, 2, 1, 0, imm, 0, 0) :
                              (k == 3 && o == 7'h23) ? pk(0, 1, 1, 0, 0, 0, 0, 0, imm, 0, 0) :
                              k == 3 ? pk(0, 1, 0, 0, 0, 0, 0, 0, imm, 0, 0) :
                                       pk(0, 0, 0, 0, 1, 0, 0, 0, imm, 1, 0);
         7'h33:   return pk(0, 0, 0, 0, 0, 2, 0, m_alu(f3, f7[5]), imm, 0, 0);
         7'h13:   return pk(0, 0, 0, 0, 0, 2, 1, m_alu(f3, 1'b0), imm, 0, 0);
         7'h6F:   return pk(1, 0, 0, 0, 0, 1, 2, 0, imm, 0, 0);
         7'h67:   return k == 2 ? pk(1, 0, 0, 0, 2, 2, 1, 0, imm, 0, 0) : pk(0, 0, 0, 0, 2, 1, 2, 0, imm, 1, 0);
         7'h63:   return pk(tk, 0, 0, 0, 0, 2, 0, 1, imm, 0, 0);
         default: return pk(0, 0, 0, 0, 3, 0, 0, 0, imm, 1, 0);
      endcase
   endfunction

   always @(negedge clk) begin
      if (active) begin
         if (!rst) chk("rst_en", act & M_EN, 18'h0);
         else chk("ctl", act, model(b.op, b.funct3, b.funct7, b.Zero, b.lt, cur_k));
         chk("cnt", b.instr_count, m_cnt);
      end
   end

   task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                      input logic z, l, input int pk_k, input logic [17:0] pmask, pval, input string nm);
      int n;
      n = cpi(o) == 0 ? 12 : cpi(o);
      b.op = o; b.funct3 = f3; b.funct7 = f7; b.Zero = z; b.lt = l;
      for (int k = 0; k < n; k++) begin
         cur_k = k;
         @(negedge clk);
         if (k == pk_k) chk(nm, act & pmask, pval);
         @(posedge clk);
         #1;
      end
      if (cpi(o) != 0) m_cnt++;
   endtask

   initial begin
      rst = 1'b0;
      b.op = 7'h33; b.funct3 = 3'd0; b.funct7 = 7'd0; b.Zero = 1'b0; b.lt = 1'b0;
      active = 1'b1;
      @(negedge clk);
      chk("rst_done", {31'd0, b.done}, 32'd0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      run(7'h03, 3'd2, 7'h00, 0, 0, 4, M_RS | M_RW, 18'h01002, "lw_memwb");
      chk("cnt_lw", b.instr_count, 32'd1);
      run(7'h33, 3'd0, 7'h20, 0, 0, 2, M_ALU, 18'h00020, "r_sub");
      run(7'h33, 3'd2, 7'h00, 0, 0, 2, M_ALU, 18'h000A0, "r_slt");
      run(7'h33, 3'd7, 7'h00, 0, 0, -1, 0, 0, "");
      run(7'h13, 3'd0, 7'h20, 0, 0, 2, M_ALU, 18'h00000, "addi_f7");
      run(7'h13, 3'd4, 7'h00, 0, 0, -1, 0, 0, "");
      run(7'h23, 3'd2, 7'h00, 0, 0, -1, 0, 0, "");
      run(7'h63, 3'd0, 7'h00, 1, 0, 2, M_PCW, 18'h20000, "beq_t");
      run(7'h63, 3'd1, 7'h00, 1, 0, 2, M_PCW, 18'h00000, "bne_nt");
      run(7'h63, 3'd4, 7'h00, 0, 1, 2, M_PCW, 18'h20000, "blt_t");
      run(7'h63, 3'd5, 7'h00, 0, 1, 2, M_PCW, 18'h00000, "bge_nt");
      run(7'h63, 3'd6, 7'h00, 1, 1, 2, M_PCW, 18'h00000, "bltu_nt");
      run(7'h6F, 3'd0, 7'h00, 0, 0, 2, M_PCW | M_RS, 18'h20000, "jal");
      run(7'h67, 3'd0, 7'h00, 0, 0, 3, M_RS | M_RW, 18'h02002, "jalrwb");
      run(7'h37, 3'd0, 7'h00, 0, 0, -1, 0, 0, "");
      chk("cnt_lit", b.instr_count, 32'd15);
      run(7'h00, 3'd0, 7'h00, 0, 0, 5, M_DONE, 18'h00001, "halt_done");
      chk("cnt_halt", b.instr_count, 32'd15);
      rst = 1'b0;
      m_cnt = 0;
      @(negedge clk);
      chk("rst2_done", {31'd0, b.done}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      run(7'h03, 3'd2, 7'h00, 0, 0, -1, 0, 0, "");
      chk("cnt_after_rst", b.instr_count, 32'd1);
      b.op = 7'h03;
      cur_k = 0;
      repeat (3) begin
         @(posedge clk);
         #1 cur_k++;
      end
      rst = 1'b0;
      m_cnt = 0;
      #1 chk("midrst_rw", {31'd0, b.RegWrite}, 32'd0);
      @(posedge clk);
      #1 active = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
